// File: rtl/alu_pkg.sv
// Shared constants and entry-packing helpers for the 4-bit ALU datapath.
// A packed result entry is laid out as {opcode, y, x}, with x in the low bits.
package alu_pkg;

    localparam int ALU_WIDTH    = 4;
    localparam int ALU_OP_WIDTH = 4;

    // Total width of one packed {opcode, y, x} entry.
    function automatic int entry_w(input int width, input int op_width);
        return 2 * width + op_width;
    endfunction

    // Field offsets (LSB positions) inside a packed entry.
    function automatic int x_lsb(input int width);
        return 0;
    endfunction

    function automatic int y_lsb(input int width);
        return width;
    endfunction

    function automatic int op_lsb(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/alu_result_ram.sv
// DEPTH x ENTRY_W register array backing the ALU result FIFO.
// The write port is synchronous and the read port is asynchronous, so the
// head entry is visible as soon as the read pointer addresses it.
// The storage is intentionally not reset; occupancy is tracked by the owner.
//
// Ports:
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  packed entry to store
//   rd_addr  read address
//   rd_data  packed entry at rd_addr (combinational)
module alu_result_ram #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 12
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [ENTRY_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [ENTRY_W-1:0]         rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_buffer.sv
// Result buffer sitting downstream of the 4-bit ALU. Each (x, y, opcode)
// result is captured into a small first-word-fall-through FIFO and offered
// to the consumer over a valid/ready handshake, so consumer back-pressure
// never causes a result to be overwritten.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        producer handshake; in_x, in_y, in_opcode data
//   out_valid/out_ready      consumer handshake; out_x, out_y, out_opcode
//                            head data, out_zero flags a head with x==y==0
//   level, full, empty       occupancy status
//   accept_count, drop_count only with ALU_RESULT_BUFFER_STATS_EN defined:
//                            wrapping push counter and saturating counter of
//                            cycles where in_valid was refused
//
// Optional feature macro: ALU_RESULT_BUFFER_STATS_EN
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int OP_WIDTH = ALU_OP_WIDTH,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_x,
    input  logic [WIDTH-1:0]             in_y,
    input  logic [OP_WIDTH-1:0]          in_opcode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_x,
    output logic [WIDTH-1:0]             out_y,
    output logic [OP_WIDTH-1:0]          out_opcode,
    output logic                         out_zero,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
`ifdef ALU_RESULT_BUFFER_STATS_EN
    ,
    output logic [7:0]                   accept_count,
    output logic [7:0]                   drop_count
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = entry_w(WIDTH, OP_WIDTH);
    localparam int X_LSB   = x_lsb(WIDTH);
    localparam int Y_LSB   = y_lsb(WIDTH);
    localparam int OP_LSB  = op_lsb(WIDTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_result_buffer: DEPTH must be a power of 2 and >= 2");
    end

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    // Flags come from the registered count only, which keeps out_ready off
    // any combinational path to in_ready.
    assign full      = (count == LVL_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign level     = count;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign wr_data = {in_opcode, in_y, in_x};

    alu_result_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointers are exactly PTR_W bits wide, so they wrap at DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The array is never reset, so stale contents are masked while empty.
    always_comb begin
        out_x      = '0;
        out_y      = '0;
        out_opcode = '0;
        out_zero   = 1'b0;
        if (!empty) begin
            out_x      = rd_data[X_LSB +: WIDTH];
            out_y      = rd_data[Y_LSB +: WIDTH];
            out_opcode = rd_data[OP_LSB +: OP_WIDTH];
            out_zero   = (rd_data[X_LSB +: WIDTH] == '0) &&
                         (rd_data[Y_LSB +: WIDTH] == '0);
        end
    end

`ifdef ALU_RESULT_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_count <= '0;
            drop_count   <= '0;
        end else begin
            if (push) begin
                accept_count <= accept_count + 8'd1;
            end
            if (in_valid && !in_ready && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: a table of per-cycle stimulus
// records with hand-derived expected levels, a queue scoreboard for data
// ordering, and hand-written reset sequences.
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic [3:0] in_opcode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic [3:0] out_opcode;
    logic       out_zero;
    logic [2:0] level;
    logic       full;
    logic       empty;
`ifdef ALU_RESULT_BUFFER_STATS_EN
    logic [7:0] accept_count;
    logic [7:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [11:0] sb[$];
    int          m_acc  = 0;
    int          m_drop = 0;

    typedef struct {
        bit       iv;
        bit       ordy;
        bit [3:0] x;
        bit [3:0] y;
        bit [3:0] op;
        int       exp_level;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_result_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_opcode (out_opcode),
        .out_zero   (out_zero),
        .level      (level),
        .full       (full),
        .empty      (empty)
`ifdef ALU_RESULT_BUFFER_STATS_EN
        ,
        .accept_count (accept_count),
        .drop_count   (drop_count)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input bit iv, input bit [3:0] x, input bit [3:0] y,
                        input bit [3:0] op, input bit ordy, input int exp_level);
        bit m_push;
        bit m_pop;
        @(negedge clk);
        in_valid  = iv;
        in_x      = x;
        in_y      = y;
        in_opcode = op;
        out_ready = ordy;
        #1;
        chk("out_valid", int'(out_valid), int'(sb.size() > 0));
        chk("in_ready", int'(in_ready), int'(sb.size() < 4));
        chk("full", int'(full), int'(sb.size() == 4));
        chk("empty", int'(empty), int'(sb.size() == 0));
        if (sb.size() > 0) begin
            chk("head_x", int'(out_x), int'(sb[0][3:0]));
            chk("head_y", int'(out_y), int'(sb[0][7:4]));
            chk("head_op", int'(out_opcode), int'(sb[0][11:8]));
            chk("out_zero", int'(out_zero), int'(sb[0][7:0] == 8'h00));
        end else begin
            chk("idle_data", int'({out_opcode, out_y, out_x}), 0);
            chk("idle_zero", int'(out_zero), 0);
        end
`ifdef ALU_RESULT_BUFFER_STATS_EN
        chk("accept_count", int'(accept_count), m_acc);
        chk("drop_count", int'(drop_count), m_drop);
`endif
        m_push = iv && (sb.size() < 4);
        m_pop  = ordy && (sb.size() > 0);
        @(posedge clk);
        if (m_pop) void'(sb.pop_front());
        if (m_push) begin
            sb.push_back({op, y, x});
            m_acc = (m_acc + 1) % 256;
        end
        if (iv && !m_push && m_drop < 255) m_drop++;
        #1;
        chk("level", int'(level), exp_level);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_x      = 4'd5;
        in_y      = 4'd6;
        in_opcode = 4'd7;
        @(posedge clk);
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_data", int'({out_opcode, out_y, out_x}), 0);
`ifdef ALU_RESULT_BUFFER_STATS_EN
        chk("rst_accept_count", int'(accept_count), 0);
        chk("rst_drop_count", int'(drop_count), 0);
`endif
        sb.delete();
        m_acc  = 0;
        m_drop = 0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single push with consumer stalled, then drain it.
        vecs.push_back('{1, 0, 4'd3, 4'd5, 4'd1, 1});
        vecs.push_back('{0, 0, 4'd0, 4'd0, 4'd0, 1});
        vecs.push_back('{0, 1, 4'd0, 4'd0, 4'd0, 0});
        // Five back-to-back pushes: the fifth is refused.
        for (int i = 1; i <= 5; i++)
            vecs.push_back('{1, 0, 4'(i), 4'd0, 4'd2, (i < 4) ? i : 4});
        // Full with both handshakes: pop happens, push is refused.
        vecs.push_back('{1, 1, 4'd9, 4'd9, 4'd9, 3});
        vecs.push_back('{0, 1, 4'd0, 4'd0, 4'd0, 2});
        vecs.push_back('{0, 1, 4'd0, 4'd0, 4'd0, 1});
        vecs.push_back('{0, 1, 4'd0, 4'd0, 4'd0, 0});
        // Empty: out_ready ignored.
        vecs.push_back('{0, 1, 4'd0, 4'd0, 4'd0, 0});
        // Sustained push+pop at level 1 across pointer wrap.
        vecs.push_back('{1, 0, 4'd6, 4'd7, 4'd3, 1});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{1, 1, 4'(i + 8), 4'(i), 4'(15 - i), 1});
        vecs.push_back('{0, 1, 4'd0, 4'd0, 4'd0, 0});
        // Zero result at head, then build level 3 for the reset test.
        vecs.push_back('{1, 0, 4'd0, 4'd0, 4'd5, 1});
        vecs.push_back('{1, 0, 4'd1, 4'd1, 4'd6, 2});
        vecs.push_back('{1, 0, 4'd2, 4'd2, 4'd7, 3});
        vecs.push_back('{0, 0, 4'd0, 4'd0, 4'd0, 3});

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_opcode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        foreach (vecs[i])
            step(vecs[i].iv, vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].ordy,
                 vecs[i].exp_level);

        // Reset with three entries held and both handshakes asserted.
        chk("pre_reset_level", int'(level), 3);
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        step(1, 4'd10, 4'd11, 4'd12, 0, 1);
        step(0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
